pio_led_blink: RTL and testbench
================================

PIO_LED_BLINK -- requirements
Module: pio_led_blink

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL take parameter WIDTH, default 8, meaning the output port width in bits (legal range 1..32).
REQ-002 The block SHALL take parameter RESET_VALUE, default 0, meaning the DATA register value after reset.
REQ-003 The block SHALL take parameter PRESCALE, default 50000, meaning the number of clk cycles per blink tick (legal range 1 or more).

Ports (name, direction, width, meaning):
REQ-004 clk, input, 1, clock; all state updates on the rising edge.
REQ-005 reset_n, input, 1, reset, asynchronous, active-low.
REQ-006 address, input, 3, Avalon-MM word address.
REQ-007 chipselect, input, 1, slave select.
REQ-008 write_n, input, 1, write strobe, active-low, qualified by chipselect.
REQ-009 writedata, input, 32, write data.
REQ-010 readdata, output, 32, read data, zero-extended.
REQ-011 out_port, output, WIDTH, LED drive.

Function
REQ-012 A write SHALL occur on any cycle where chipselect=1 and write_n=0; there SHALL be zero wait states and a single-cycle effect.
REQ-013 Register map:
- 0 DATA (RW)
- 1 OUTSET (WO; each 1 bit sets the DATA bit)
- 2 OUTCLR (WO; each 1 bit clears the DATA bit)
- 3 BLINK_MASK (RW, WIDTH bits)
- 4 BLINK_PERIOD (RW, 16 bits, in ticks)
- 5 STATUS (RO; bit0 = phase)
REQ-014 readdata SHALL be combinational from address, with no chipselect qualification.
- OUTSET and OUTCLR SHALL read 0.
- Addresses 6 and 7 SHALL read 0.
- Writes to STATUS, 6 and 7 SHALL be ignored.
REQ-015 Register writes SHALL use writedata[WIDTH-1:0]; BLINK_PERIOD writes SHALL use writedata[15:0].
REQ-016 out_port SHALL equal DATA XOR (BLINK_MASK AND {WIDTH{phase}}), registered-free, so it follows register state in the same cycle.
REQ-017 Prescaler: counts 0..PRESCALE-1 and wraps.
- tick SHALL be 1 for one clk cycle when the count equals PRESCALE-1.
- PRESCALE=1 SHALL give tick every cycle.
REQ-018 Period counter:
- SHALL increment on tick.
- On the tick where count = BLINK_PERIOD-1, it SHALL clear to 0 and phase SHALL toggle.
REQ-019 BLINK_PERIOD=0 SHALL disable blinking: prescaler, period counter and phase SHALL be held at 0.
REQ-020 Any write to BLINK_PERIOD SHALL clear the prescaler, the period counter and phase to 0 on the same edge; the write takes priority over a coincident tick.
REQ-021 A DATA, OUTSET, OUTCLR or BLINK_MASK write coincident with a phase toggle SHALL apply both effects on the same edge.
REQ-022 A BLINK_MASK write SHALL NOT disturb the counters or phase.

Reset
REQ-023 On reset_n=0, the block SHALL set the following asynchronously, independent of clk:
- DATA=RESET_VALUE
- BLINK_MASK=0
- BLINK_PERIOD=0
- prescaler=0
- period counter=0
- phase=0
REQ-024 After reset, out_port SHALL equal RESET_VALUE[WIDTH-1:0] and readdata of address 0 SHALL equal the same value.
REQ-025 Reset asserted mid-blink SHALL abort the period with no residual toggle after release.

Configuration
REQ-026 Macro PIO_LED_BLINK_EN, when defined, SHALL include the blink engine per REQ-016 to REQ-022.
REQ-027 Without PIO_LED_BLINK_EN:
- out_port SHALL equal DATA.
- Addresses 3, 4 and 5 SHALL read 0 and ignore writes.
- No prescaler or counter logic SHALL be synthesised.
- DATA, OUTSET and OUTCLR SHALL behave identically to the enabled build.

Verification
REQ-028 Reset with RESET_VALUE=8'hA5: out_port=8'hA5 and DATA reads 32'h000000A5 during and after reset.
REQ-029 DATA=8'h0F, then OUTSET 8'hF0 -> DATA=8'hFF; then OUTCLR 8'h81 -> DATA=8'h7E; OUTSET and OUTCLR read 0.
REQ-030 PRESCALE=4, DATA=8'h00, MASK=8'h03, PERIOD=2: out_port toggles 8'h00/8'h03 every 8 clk cycles; STATUS bit0 tracks phase.
REQ-031 While blinking with phase=1, write PERIOD=0: on the next edge phase=0 and out_port=DATA, with no further toggles over 100 cycles.
REQ-032 Write PERIOD=2 on a tick cycle: counters restart, and the first toggle occurs exactly 2*PRESCALE cycles after the write.
REQ-033 Build without PIO_LED_BLINK_EN: write MASK=8'hFF and PERIOD=1 -> addresses 3 and 4 read 0 and out_port=DATA constant.

Source files
------------

// File: rtl/pio_led_blink.sv
// pio_led_blink: Avalon-MM LED output port with an optional blink engine.
// Register map (word address):
//   0 DATA          RW
//   1 OUTSET        WO, each 1 bit sets the matching DATA bit
//   2 OUTCLR        WO, each 1 bit clears the matching DATA bit
//   3 BLINK_MASK    RW, WIDTH bits          (blink build only)
//   4 BLINK_PERIOD  RW, 16 bits, in ticks   (blink build only)
//   5 STATUS        RO, bit0 = phase        (blink build only)
// Define PIO_LED_BLINK_EN to build the blink engine; without it the block is a
// plain output port and addresses 3..5 read 0 and ignore writes.
module pio_led_blink #(
   parameter int          WIDTH       = 8,
   parameter logic [31:0] RESET_VALUE = 32'd0,
   parameter int          PRESCALE    = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [WIDTH-1:0] RESET_DATA = RESET_VALUE[WIDTH-1:0];

   logic             wr_en;
   logic [WIDTH-1:0] wr_bits;
   logic [WIDTH-1:0] data;
   logic             unused_bits;

   assign wr_en       = chipselect & ~write_n;
   assign wr_bits     = writedata[WIDTH-1:0];
   assign unused_bits = ^writedata;

   // DATA register with direct, set and clear write ports
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data <= RESET_DATA;
      end else if (wr_en) begin
         case (address)
            3'd0:    data <= wr_bits;
            3'd1:    data <= data | wr_bits;
            3'd2:    data <= data & ~wr_bits;
            default: data <= data;
         endcase
      end
   end

`ifdef PIO_LED_BLINK_EN

   localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

   logic [WIDTH-1:0] mask;
   logic [15:0]      period;
   logic [15:0]      period_cnt;
   logic [PW-1:0]    presc;
   logic             phase;
   logic             tick;
   logic             period_wr;

   assign period_wr = wr_en && (address == 3'd4);
   assign tick      = (presc == PRESC_LAST);

   // Blink configuration registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask   <= '0;
         period <= '0;
      end else if (wr_en) begin
         if (address == 3'd3) mask <= wr_bits;
         if (address == 3'd4) period <= writedata[15:0];
      end
   end

   // Prescaler, period counter and phase; a period write or a zero period
   // holds everything at 0 and wins over a coincident tick
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc      <= '0;
         period_cnt <= '0;
         phase      <= 1'b0;
      end else if (period_wr || (period == 16'd0)) begin
         presc      <= '0;
         period_cnt <= '0;
         phase      <= 1'b0;
      end else begin
         if (tick) presc <= '0;
         else      presc <= presc + PW'(1);
         if (tick) begin
            if (period_cnt == period - 16'd1) begin
               period_cnt <= '0;
               phase      <= ~phase;
            end else begin
               period_cnt <= period_cnt + 16'd1;
            end
         end
      end
   end

   assign out_port = data ^ (mask & {WIDTH{phase}});

   // Read mux, combinational from address alone
   always_comb begin
      readdata = 32'd0;
      case (address)
         3'd0:    readdata = 32'(data);
         3'd3:    readdata = 32'(mask);
         3'd4:    readdata = 32'(period);
         3'd5:    readdata = {31'd0, phase};
         default: readdata = 32'd0;
      endcase
   end

`else

   assign out_port = data;

   // Read mux, combinational from address alone
   always_comb begin
      readdata = 32'd0;
      if (address == 3'd0) readdata = 32'(data);
   end

`endif

endmodule

// File: tb/tb_pio_led_blink.sv
// Directed bench for pio_led_blink (WIDTH=8, RESET_VALUE=8'hA5, PRESCALE=4).
// Blink checks are built when PIO_LED_BLINK_EN is defined, the disabled-build
// checks otherwise.
module tb_pio_led_blink;

   localparam int          WIDTH    = 8;
   localparam int          PRESCALE = 4;
   localparam logic [31:0] RV       = 32'hA5;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [2:0]       address = 3'd0;
   logic             chipselect = 1'b0;
   logic             write_n = 1'b1;
   logic [31:0]      writedata = 32'd0;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] out_port;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] rv;

   pio_led_blink #(.WIDTH(WIDTH), .RESET_VALUE(RV), .PRESCALE(PRESCALE)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .out_port(out_port)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // reset behaviour, during and after
      #25;
      chk("rst_out", 32'(out_port), 32'hA5);
      rd(3'd0, rv); chk("rst_data", rv, 32'h000000A5);
      @(negedge clk); reset_n = 1'b1;
      step(2);
      chk("post_rst_out", 32'(out_port), 32'hA5);
      rd(3'd0, rv); chk("post_rst_data", rv, 32'h000000A5);

      // DATA / OUTSET / OUTCLR
      wr(3'd0, 32'h0F);
      rd(3'd0, rv); chk("data_0f", rv, 32'h0F);
      wr(3'd1, 32'hF0);
      rd(3'd0, rv); chk("outset", rv, 32'hFF);
      wr(3'd2, 32'h81);
      rd(3'd0, rv); chk("outclr", rv, 32'h7E);
      chk("out_7e", 32'(out_port), 32'h7E);
      rd(3'd1, rv); chk("rd_outset", rv, 32'd0);
      rd(3'd2, rv); chk("rd_outclr", rv, 32'd0);
      rd(3'd6, rv); chk("rd_a6", rv, 32'd0);
      rd(3'd7, rv); chk("rd_a7", rv, 32'd0);
      wr(3'd5, 32'hFF); wr(3'd6, 32'hFF); wr(3'd7, 32'hFF);
      rd(3'd0, rv); chk("ign_wr_567", rv, 32'h7E);
      rd(3'd5, rv); chk("status_idle", rv, 32'd0);

`ifdef PIO_LED_BLINK_EN
      // basic blink: toggle every 2*PRESCALE cycles
      wr(3'd0, 32'h00);
      wr(3'd3, 32'h03);
      rd(3'd3, rv); chk("rd_mask", rv, 32'h03);
      wr(3'd4, 32'h02);
      rd(3'd4, rv); chk("rd_period", rv, 32'h02);
      for (int k = 1; k <= 12; k++) begin
         step(1);
         chk($sformatf("blink_k%0d", k), 32'(out_port), ((k / 8) % 2 == 1) ? 32'h03 : 32'h00);
      end
      rd(3'd5, rv); chk("status_ph1", rv, 32'd1);

      // disable mid-phase
      wr(3'd4, 32'h00);
      chk("dis_out", 32'(out_port), 32'h00);
      rd(3'd5, rv); chk("dis_status", rv, 32'd0);
      for (int k = 0; k < 100; k++) begin
         step(1);
         chk("dis_hold", 32'(out_port), 32'h00);
      end

      // restart by period write coincident with a tick
      wr(3'd0, 32'h50);
      wr(3'd4, 32'h02);
      step(3);
      chk("pre_restart", 32'(out_port), 32'h50);
      wr(3'd4, 32'h02);
      step(7);
      chk("restart_k7", 32'(out_port), 32'h50);
      step(1);
      chk("restart_k8", 32'(out_port), 32'h53);
      rd(3'd5, rv); chk("restart_status", rv, 32'd1);
      step(7);
      chk("restart_k15", 32'(out_port), 32'h53);

      // OUTSET coincident with a toggle
      wr(3'd1, 32'h80);
      chk("coinc_out", 32'(out_port), 32'hD0);
      rd(3'd0, rv); chk("coinc_data", rv, 32'hD0);

      // mask write does not disturb timing
      step(3);
      wr(3'd3, 32'h0F);
      chk("mask_k20", 32'(out_port), 32'hD0);
      step(3);
      chk("mask_k23", 32'(out_port), 32'hD0);
      step(1);
      chk("mask_k24", 32'(out_port), 32'hDF);

      // reset mid-blink
      reset_n = 1'b0;
      #1;
      chk("midrst_out", 32'(out_port), 32'hA5);
      rd(3'd5, rv); chk("midrst_status", rv, 32'd0);
      step(2);
      @(negedge clk); reset_n = 1'b1;
      step(1);
      wr(3'd3, 32'hFF);
      for (int k = 0; k < 20; k++) begin
         step(1);
         chk("postrst_hold", 32'(out_port), 32'hA5);
      end
      rd(3'd5, rv); chk("postrst_status", rv, 32'd0);
`else
      // blink registers absent
      wr(3'd3, 32'hFF);
      wr(3'd4, 32'h01);
      rd(3'd3, rv); chk("nb_rd_mask", rv, 32'd0);
      rd(3'd4, rv); chk("nb_rd_period", rv, 32'd0);
      rd(3'd5, rv); chk("nb_rd_status", rv, 32'd0);
      for (int k = 0; k < 20; k++) begin
         step(1);
         chk("nb_out_const", 32'(out_port), 32'h7E);
      end
      rd(3'd0, rv); chk("nb_data", rv, 32'h7E);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
